// File: rtl/rvc_pkg.sv
// Shared RV32I/RVC encoding constants and packer state type for rvc_compress_packer.
package rvc_pkg;

  localparam logic [6:0] OP_IMM = 7'b0010011;
  localparam logic [6:0] OP     = 7'b0110011;
  localparam logic [6:0] LOAD   = 7'b0000011;
  localparam logic [6:0] STORE  = 7'b0100011;
  localparam logic [6:0] JAL    = 7'b1101111;
  localparam logic [6:0] BRANCH = 7'b1100011;

  localparam logic [2:0] F3_ADD = 3'b000;
  localparam logic [2:0] F3_W   = 3'b010;
  localparam logic [2:0] F3_BEQ = 3'b000;

  localparam logic [1:0] C_Q0 = 2'b00;
  localparam logic [1:0] C_Q1 = 2'b01;
  localparam logic [1:0] C_Q2 = 2'b10;

  localparam logic [2:0] CF3_ADDI = 3'b000;
  localparam logic [2:0] CF3_LW   = 3'b010;
  localparam logic [2:0] CF3_SW   = 3'b110;
  localparam logic [2:0] CF3_J    = 3'b101;
  localparam logic [2:0] CF3_BEQZ = 3'b110;
  localparam logic [3:0] CF4_ADD  = 4'b1001;

  localparam logic [15:0] C_NOP = 16'h0001;

  typedef enum logic [1:0] {EMPTY, HALF, FLUSH_PAD} pack_state_t;

  // x8..x15 are the only registers reachable through the 3-bit RVC fields.
  function automatic logic is_creg(input logic [4:0] r);
    return r[4:3] == 2'b01;
  endfunction

endpackage

// File: rtl/rvc_compress_packer_if.sv
// Stream-in / word-out bundle for rvc_compress_packer; RVC_STATS_EN adds the stat counters.
interface rvc_compress_packer_if #(
  parameter int unsigned ADDR_W = 10
);
  logic              in_valid;
  logic              in_ready;
  logic [31:0]       in_instr;
  logic              comp_en;
  logic              flush;
  logic              flush_done;
  logic              out_valid;
  logic              out_ready;
  logic [31:0]       out_word;
  logic [ADDR_W-1:0] out_addr;
  logic              half_pending;
`ifdef RVC_STATS_EN
  logic [15:0]       stat_total;
  logic [15:0]       stat_comp;

  modport master (
    output in_valid, in_instr, comp_en, flush, out_ready,
    input  in_ready, flush_done, out_valid, out_word, out_addr, half_pending,
    input  stat_total, stat_comp
  );
  modport slave (
    input  in_valid, in_instr, comp_en, flush, out_ready,
    output in_ready, flush_done, out_valid, out_word, out_addr, half_pending,
    output stat_total, stat_comp
  );
`else
  modport master (
    output in_valid, in_instr, comp_en, flush, out_ready,
    input  in_ready, flush_done, out_valid, out_word, out_addr, half_pending
  );
  modport slave (
    input  in_valid, in_instr, comp_en, flush, out_ready,
    output in_ready, flush_done, out_valid, out_word, out_addr, half_pending
  );
`endif
endinterface

// File: rtl/rvc_compressor.sv
// Combinational RV32I -> RVC encoder; first matching rule wins, offsets copied bit-for-bit.
module rvc_compressor
  import rvc_pkg::*;
(
  input  logic [31:0] in_instr,
  input  logic        comp_en,
  output logic        is_c,
  output logic [15:0] c_instr
);

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [4:0]  rd;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [11:0] imm_i;
  logic [11:0] imm_s;
  logic [12:1] imm_b;
  logic [20:1] imm_j;

  assign opcode = in_instr[6:0];
  assign rd     = in_instr[11:7];
  assign funct3 = in_instr[14:12];
  assign rs1    = in_instr[19:15];
  assign rs2    = in_instr[24:20];
  assign funct7 = in_instr[31:25];
  assign imm_i  = in_instr[31:20];
  assign imm_s  = {in_instr[31:25], in_instr[11:7]};
  assign imm_b  = {in_instr[31], in_instr[7], in_instr[30:25], in_instr[11:8]};
  assign imm_j  = {in_instr[31], in_instr[19:12], in_instr[20], in_instr[30:21]};

  logic sel_nop, sel_addi, sel_add, sel_lw, sel_sw, sel_j, sel_beqz;

  assign sel_nop  = in_instr == 32'h0000_0013;
  assign sel_addi = (opcode == OP_IMM) && (funct3 == F3_ADD) && (rd != 5'd0) && (rd == rs1) &&
                    ((imm_i[11:5] == 7'h00) || (imm_i[11:5] == 7'h7f)) && (imm_i != 12'd0);
  assign sel_add  = (opcode == OP) && (funct3 == F3_ADD) && (funct7 == 7'd0) &&
                    (rd != 5'd0) && (rd == rs1) && (rs2 != 5'd0);
  assign sel_lw   = (opcode == LOAD) && (funct3 == F3_W) && is_creg(rd) && is_creg(rs1) &&
                    (imm_i[11:7] == 5'd0) && (imm_i[1:0] == 2'd0);
  assign sel_sw   = (opcode == STORE) && (funct3 == F3_W) && is_creg(rs2) && is_creg(rs1) &&
                    (imm_s[11:7] == 5'd0) && (imm_s[1:0] == 2'd0);
  assign sel_j    = (opcode == JAL) && (rd == 5'd0) &&
                    ((imm_j[20:11] == 10'h000) || (imm_j[20:11] == 10'h3ff));
  assign sel_beqz = (opcode == BRANCH) && (funct3 == F3_BEQ) && (rs2 == 5'd0) && is_creg(rs1) &&
                    ((imm_b[12:8] == 5'h00) || (imm_b[12:8] == 5'h1f));

  always_comb begin
    is_c    = 1'b0;
    c_instr = 16'd0;
    if (comp_en) begin
      is_c = 1'b1;
      if (sel_nop) begin
        c_instr = C_NOP;
      end else if (sel_addi) begin
        c_instr = {CF3_ADDI, imm_i[5], rd, imm_i[4:0], C_Q1};
      end else if (sel_add) begin
        c_instr = {CF4_ADD, rd, rs2, C_Q2};
      end else if (sel_lw) begin
        c_instr = {CF3_LW, imm_i[5:3], rs1[2:0], imm_i[2], imm_i[6], rd[2:0], C_Q0};
      end else if (sel_sw) begin
        c_instr = {CF3_SW, imm_s[5:3], rs1[2:0], imm_s[2], imm_s[6], rs2[2:0], C_Q0};
      end else if (sel_j) begin
        c_instr = {CF3_J, imm_j[11], imm_j[4], imm_j[9:8], imm_j[10], imm_j[6], imm_j[7],
                   imm_j[3:1], imm_j[5], C_Q1};
      end else if (sel_beqz) begin
        c_instr = {CF3_BEQZ, imm_b[8], imm_b[4:3], rs1[2:0], imm_b[7:6], imm_b[2:1], imm_b[5],
                   C_Q1};
      end else begin
        is_c = 1'b0;
      end
    end
  end

endmodule

// File: rtl/rvc_compress_packer.sv
// Compresses an RV32I stream and packs halfwords little-endian into IMEM words.
// Build with RVC_STATS_EN to add saturating stat_total/stat_comp counters.
module rvc_compress_packer
  import rvc_pkg::*;
#(
  parameter int unsigned       ADDR_W    = 10,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input logic                  clk,
  input logic                  rst,
  rvc_compress_packer_if.slave bus
);

  logic        is_c;
  logic [15:0] c_instr;

  rvc_compressor u_compressor (
    .in_instr (bus.in_instr),
    .comp_en  (bus.comp_en),
    .is_c     (is_c),
    .c_instr  (c_instr)
  );

  pack_state_t       state_q;
  logic [15:0]       pend_q;
  logic              flush_q;
  logic              pad_sent_q;
  logic              out_valid_q;
  logic [31:0]       out_word_q;
  logic [ADDR_W-1:0] out_addr_q;
  logic              flush_done_q;

  logic out_free, in_hs, out_hs, flush_req;

  assign out_free  = !out_valid_q || bus.out_ready;
  assign in_hs     = bus.in_valid && bus.in_ready;
  assign out_hs    = out_valid_q && bus.out_ready;
  assign flush_req = bus.flush || flush_q;

  assign bus.in_ready     = !rst && (state_q != FLUSH_PAD) && out_free;
  assign bus.out_valid    = out_valid_q;
  assign bus.out_word     = out_word_q;
  assign bus.out_addr     = out_addr_q;
  assign bus.half_pending = state_q == HALF;
  assign bus.flush_done   = flush_done_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= EMPTY;
      pend_q       <= 16'd0;
      flush_q      <= 1'b0;
      pad_sent_q   <= 1'b0;
      out_valid_q  <= 1'b0;
      out_word_q   <= 32'd0;
      out_addr_q   <= BASE_ADDR;
      flush_done_q <= 1'b0;
    end else begin
      flush_done_q <= 1'b0;
      if (out_hs) begin
        out_valid_q <= 1'b0;
        out_addr_q  <= out_addr_q + 1'b1;
      end
      unique case (state_q)
        EMPTY: begin
          if (in_hs) begin
            if (is_c) begin
              pend_q  <= c_instr;
              state_q <= HALF;
            end else begin
              out_word_q  <= bus.in_instr;
              out_valid_q <= 1'b1;
            end
            flush_q <= flush_req;
          end else if (flush_req) begin
            // Nothing to pad; only wait for the output register to drain.
            if (out_free) begin
              flush_done_q <= 1'b1;
              flush_q      <= 1'b0;
            end else begin
              flush_q <= 1'b1;
            end
          end
        end
        HALF: begin
          if (in_hs) begin
            out_valid_q <= 1'b1;
            if (is_c) begin
              out_word_q <= {c_instr, pend_q};
              state_q    <= EMPTY;
            end else begin
              out_word_q <= {bus.in_instr[15:0], pend_q};
              pend_q     <= bus.in_instr[31:16];
            end
            flush_q <= flush_req;
          end else if (flush_req) begin
            state_q <= FLUSH_PAD;
            flush_q <= 1'b0;
          end
        end
        FLUSH_PAD: begin
          // Stay here until the padded word is taken so flush_done follows its handshake.
          if (!pad_sent_q) begin
            if (out_free) begin
              out_word_q  <= {C_NOP, pend_q};
              out_valid_q <= 1'b1;
              pad_sent_q  <= 1'b1;
            end
          end else if (out_hs) begin
            state_q      <= EMPTY;
            pad_sent_q   <= 1'b0;
            flush_done_q <= 1'b1;
          end
        end
        default: state_q <= EMPTY;
      endcase
    end
  end

`ifdef RVC_STATS_EN
  logic [15:0] stat_total_q;
  logic [15:0] stat_comp_q;

  assign bus.stat_total = stat_total_q;
  assign bus.stat_comp  = stat_comp_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      stat_total_q <= 16'd0;
      stat_comp_q  <= 16'd0;
    end else if (in_hs) begin
      if (stat_total_q != 16'hFFFF) stat_total_q <= stat_total_q + 16'd1;
      if (is_c && (stat_comp_q != 16'hFFFF)) stat_comp_q <= stat_comp_q + 16'd1;
    end
  end
`endif

endmodule
